lcd_digit_writer: RTL and testbench

Parameterised HD44780-style character LCD controller for an 8-bit data bus. After reset it runs the LCD power-up and initialisation sequence by itself. It then refreshes line 1 of the display with `NUM_DIGITS` BCD/hex digits on request. The block replaces a hand-muxed LCD datapath with its own sequencing FSM, enable-pulse generation, command wait timing, configurable digit count and selectable hex rendering. It sits between the counter/display logic and the LCD pins.

---
 rtl/lcd_pkg.sv | 56 +++++
 rtl/lcd_xfer.sv | 122 ++++++++++++
 rtl/lcd_digit_writer.sv | 202 ++++++++++++++++++++
 tb/tb_lcd_digit_writer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style character LCD writer.
//   - LCD command bytes used by the init and refresh sequences
//   - bus value driven while no transfer is in progress
//   - top-level sequencer and transfer-engine state encodings
//   - nibble-to-character mapping and init command lookup
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] LCD_DISP_ON  = 8'h0E;  // display on, cursor on
    localparam logic [7:0] LCD_ENTRY    = 8'h06;  // increment, no shift
    localparam logic [7:0] LCD_CLEAR    = 8'h01;  // clear display (long execution)
    localparam logic [7:0] LCD_ADDR0    = 8'h80;  // DDRAM address 0 (line 1, column 0)

    localparam logic [7:0] LCD_IDLE_BUS = 8'hCC;

    localparam int unsigned INIT_CMDS = 4;

    typedef enum logic [1:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_REFRESH
    } lcd_state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_E_HIGH,
        PH_WAIT
    } xfer_phase_e;

    // Digits 0..9 map to ASCII '0'..'9'; 10..15 map to 'A'..'F' or a blank.
    function automatic logic [7:0] to_char(input logic [3:0] nibble, input logic hex_mode);
        logic [7:0] ch;
        if (nibble < 4'd10) begin
            ch = {4'h3, nibble};
        end else if (hex_mode) begin
            ch = 8'h41 + {4'h0, nibble} - 8'd10;
        end else begin
            ch = 8'h20;
        end
        return ch;
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = LCD_FUNC_SET;
            2'd1:    cmd = LCD_DISP_ON;
            2'd2:    cmd = LCD_ENTRY;
            default: cmd = LCD_CLEAR;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_xfer.sv
// Single-transfer timing engine for the LCD bus.
// A start pulse latches a byte and RS and runs SETUP (1 cycle, E low),
// E_HIGH (E_PULSE_CYC cycles, E high) and WAIT (CMD_WAIT_CYC or
// CLEAR_WAIT_CYC cycles, E low). DB/RS are held for the whole transfer and
// return to the idle bus value when a transfer ends without a follow-on start.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a transfer (only when idle or on xfer_done)
//   xfer_byte, xfer_rs  byte and register select for the transfer
//   long_wait           use CLEAR_WAIT_CYC for the WAIT phase
//   lcd_db, lcd_rs      registered LCD bus and register select
//   lcd_e               registered enable strobe
//   xfer_done           high during the last WAIT cycle of a transfer
module lcd_xfer
    import lcd_pkg::*;
#(
    parameter int unsigned E_PULSE_CYC    = 12,
    parameter int unsigned CMD_WAIT_CYC   = 2500,
    parameter int unsigned CLEAR_WAIT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] xfer_byte,
    input  logic       xfer_rs,
    input  logic       long_wait,
    output logic [7:0] lcd_db,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic       xfer_done
);

    localparam int unsigned MAX_A    = (E_PULSE_CYC > CMD_WAIT_CYC) ? E_PULSE_CYC : CMD_WAIT_CYC;
    localparam int unsigned MAX_WAIT = (MAX_A > CLEAR_WAIT_CYC) ? MAX_A : CLEAR_WAIT_CYC;
    localparam int unsigned CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(E_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYC - 1);

    xfer_phase_e      phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             long_q, long_d;
    logic [7:0]       db_q, db_d;
    logic             rs_q, rs_d;
    logic             e_q, e_d;
    logic [CNT_W-1:0] wait_last;

    assign wait_last = long_q ? CLEAR_LAST : CMD_LAST;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        long_d    = long_q;
        db_d      = db_q;
        rs_d      = rs_q;
        xfer_done = 1'b0;

        case (phase_q)
            PH_SETUP: begin
                phase_d = PH_E_HIGH;
                cnt_d   = '0;
            end
            PH_E_HIGH: begin
                if (cnt_q == E_LAST) begin
                    phase_d = PH_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PH_WAIT: begin
                if (cnt_q == wait_last) begin
                    xfer_done = 1'b1;
                    phase_d   = PH_IDLE;
                    db_d      = LCD_IDLE_BUS;
                    rs_d      = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase

        // A start on the final WAIT cycle chains the next transfer with no gap.
        if (start) begin
            phase_d = PH_SETUP;
            cnt_d   = '0;
            long_d  = long_wait;
            db_d    = xfer_byte;
            rs_d    = xfer_rs;
        end

        // E is derived from the next phase and registered, so it cannot glitch.
        e_d = (phase_d == PH_E_HIGH);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            long_q  <= 1'b0;
            db_q    <= LCD_IDLE_BUS;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            long_q  <= long_d;
            db_q    <= db_d;
            rs_q    <= rs_d;
            e_q     <= e_d;
        end
    end

    assign lcd_db = db_q;
    assign lcd_rs = rs_q;
    assign lcd_e  = e_q;

endmodule

// File: rtl/lcd_digit_writer.sv
// HD44780-style LCD controller: runs power-up wait and init by itself, then
// writes NUM_DIGITS characters to line 1 on each refresh request.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   digits            digit nibbles, nibble NUM_DIGITS-1 is leftmost
//   update            single-cycle refresh request
//   busy              high during init and refresh
//   done              one-cycle pulse when a refresh completes
//   lcd_db, lcd_rs    LCD data bus and register select (0 = command)
//   lcd_rw            always 0 (write only)
//   lcd_e             LCD enable strobe
module lcd_digit_writer
    import lcd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter bit          HEX_MODE       = 1'b1,
    parameter int unsigned PWR_WAIT_CYC   = 750000,
    parameter int unsigned E_PULSE_CYC    = 12,
    parameter int unsigned CMD_WAIT_CYC   = 2500,
    parameter int unsigned CLEAR_WAIT_CYC = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    update,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              lcd_db,
    output logic                    lcd_rs,
    output logic                    lcd_rw,
    output logic                    lcd_e
);

    localparam int unsigned PWR_W   = (PWR_WAIT_CYC > 1) ? $clog2(PWR_WAIT_CYC) : 1;
    localparam int unsigned IDX_MAX = (NUM_DIGITS > INIT_CMDS - 1) ? NUM_DIGITS : INIT_CMDS - 1;
    localparam int unsigned IDX_W   = $clog2(IDX_MAX + 1);

    localparam logic [PWR_W-1:0] PWR_LAST  = PWR_W'(PWR_WAIT_CYC - 1);
    localparam logic [IDX_W-1:0] INIT_LAST = IDX_W'(INIT_CMDS - 1);
    // Index 0 is the address command, 1..NUM_DIGITS are the data bytes.
    localparam logic [IDX_W-1:0] REF_LAST  = IDX_W'(NUM_DIGITS);

    lcd_state_e              state_q, state_d;
    logic [PWR_W-1:0]        pwr_cnt_q, pwr_cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
    logic                    snap_req_q, snap_req_d;
    logic                    pending_q, pending_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic       xfer_start;
    logic [7:0] xfer_byte;
    logic       xfer_rs;
    logic       xfer_long;
    logic       xfer_done;
    logic       seq_end;
    logic [3:0] cur_nibble;

    assign xfer_long = !xfer_rs && (xfer_byte == LCD_CLEAR);

    // Nibble for the data byte that follows index idx_q (leftmost first).
    always_comb begin
        cur_nibble = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(NUM_DIGITS - 1 - i) == idx_q) begin
                cur_nibble = snap_q[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pwr_cnt_d  = pwr_cnt_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        snap_req_d = snap_req_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        // Requests arriving while busy merge into a single pending refresh.
        pending_d  = pending_q | (update && (state_q != ST_IDLE));
        xfer_start = 1'b0;
        xfer_byte  = LCD_IDLE_BUS;
        xfer_rs    = 1'b0;
        seq_end    = 1'b0;

        case (state_q)
            ST_PWR_WAIT: begin
                if (pwr_cnt_q == PWR_LAST) begin
                    state_d    = ST_INIT;
                    idx_d      = '0;
                    xfer_start = 1'b1;
                    xfer_byte  = init_cmd(2'd0);
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 1'b1;
                end
            end
            ST_INIT: begin
                if (xfer_done) begin
                    if (idx_q == INIT_LAST) begin
                        seq_end = 1'b1;
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        xfer_start = 1'b1;
                        xfer_byte  = init_cmd(2'(idx_q + 1'b1));
                    end
                end
            end
            ST_IDLE: begin
                if (update) begin
                    state_d    = ST_REFRESH;
                    snap_d     = digits;
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    xfer_start = 1'b1;
                    xfer_byte  = LCD_ADDR0;
                end
            end
            ST_REFRESH: begin
                // A refresh launched from the pending flag samples digits
                // at the end of its first cycle.
                if (snap_req_q) begin
                    snap_d     = digits;
                    snap_req_d = 1'b0;
                end
                if (xfer_done) begin
                    if (idx_q == REF_LAST) begin
                        seq_end = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        xfer_start = 1'b1;
                        xfer_byte  = to_char(cur_nibble, HEX_MODE);
                        xfer_rs    = 1'b1;
                    end
                end
            end
            default: state_d = ST_PWR_WAIT;
        endcase

        // End of init or refresh: chain straight into a refresh if one is
        // owed (including a request on this very cycle), otherwise go idle.
        if (seq_end) begin
            pending_d = 1'b0;
            idx_d     = '0;
            if (pending_q || update) begin
                state_d    = ST_REFRESH;
                snap_req_d = 1'b1;
                xfer_start = 1'b1;
                xfer_byte  = LCD_ADDR0;
                xfer_rs    = 1'b0;
            end else begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_PWR_WAIT;
            pwr_cnt_q  <= '0;
            idx_q      <= '0;
            snap_q     <= '0;
            snap_req_q <= 1'b0;
            pending_q  <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pwr_cnt_q  <= pwr_cnt_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            snap_req_q <= snap_req_d;
            pending_q  <= pending_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    lcd_xfer #(
        .E_PULSE_CYC   (E_PULSE_CYC),
        .CMD_WAIT_CYC  (CMD_WAIT_CYC),
        .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC)
    ) u_xfer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (xfer_start),
        .xfer_byte(xfer_byte),
        .xfer_rs  (xfer_rs),
        .long_wait(xfer_long),
        .lcd_db   (lcd_db),
        .lcd_rs   (lcd_rs),
        .lcd_e    (lcd_e),
        .xfer_done(xfer_done)
    );

    assign busy   = busy_q;
    assign done   = done_q;
    assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_digit_writer.sv
// Self-checking bench for lcd_digit_writer: two instances (hex and blank
// rendering) share stimulus; a cycle-level model predicts bytes, busy and
// done, and a negedge monitor compares the DUT bus against the scoreboard.
module tb_lcd_digit_writer;

    localparam int N        = 4;
    localparam int PWR      = 20;
    localparam int EP       = 2;
    localparam int CW       = 4;
    localparam int CLW      = 10;
    localparam int XFER     = 1 + EP + CW;
    localparam int REF_LEN  = (N + 1) * XFER;
    localparam int INIT_LEN = PWR + 3 * XFER + (1 + EP + CLW);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        update = 1'b0;
    logic [15:0] digits = 16'h0000;

    logic       busy_h, done_h, rs_h, rw_h, e_h;
    logic [7:0] db_h;
    logic       busy_s, done_s, rs_s, rw_s, e_s;
    logic [7:0] db_s;

    always #5 clk = ~clk;

    lcd_digit_writer #(
        .NUM_DIGITS(N), .HEX_MODE(1'b1), .PWR_WAIT_CYC(PWR),
        .E_PULSE_CYC(EP), .CMD_WAIT_CYC(CW), .CLEAR_WAIT_CYC(CLW)
    ) u_hex (
        .clk(clk), .rst_n(rst_n), .digits(digits), .update(update),
        .busy(busy_h), .done(done_h), .lcd_db(db_h), .lcd_rs(rs_h),
        .lcd_rw(rw_h), .lcd_e(e_h)
    );

    lcd_digit_writer #(
        .NUM_DIGITS(N), .HEX_MODE(1'b0), .PWR_WAIT_CYC(PWR),
        .E_PULSE_CYC(EP), .CMD_WAIT_CYC(CW), .CLEAR_WAIT_CYC(CLW)
    ) u_spc (
        .clk(clk), .rst_n(rst_n), .digits(digits), .update(update),
        .busy(busy_s), .done(done_s), .lcd_db(db_s), .lcd_rs(rs_s),
        .lcd_rw(rw_s), .lcd_e(e_s)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [8:0] exp_q_h[$];
    logic [8:0] exp_q_s[$];
    int cyc;
    int busy_end;
    int snap_at;
    bit model_busy;
    bit cur_is_refresh;
    bit m_pending;
    bit exp_done;

    function automatic logic [7:0] char_of(input logic [3:0] n, input bit hex);
        int v;
        v = int'(n);
        if (v <= 9) return 8'(48 + v);
        if (hex) return 8'(65 + v - 10);
        return 8'h20;
    endfunction

    task automatic push_init();
        logic [7:0] cmds [4];
        cmds = '{8'h38, 8'h0E, 8'h06, 8'h01};
        for (int i = 0; i < 4; i++) begin
            exp_q_h.push_back({1'b0, cmds[i]});
            exp_q_s.push_back({1'b0, cmds[i]});
        end
    endtask

    task automatic push_refresh(input logic [15:0] d);
        logic [3:0] nib;
        exp_q_h.push_back({1'b0, 8'h80});
        exp_q_s.push_back({1'b0, 8'h80});
        for (int k = N - 1; k >= 0; k--) begin
            nib = d[4*k +: 4];
            exp_q_h.push_back({1'b1, char_of(nib, 1'b1)});
            exp_q_s.push_back({1'b1, char_of(nib, 1'b0)});
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q_h.delete();
            exp_q_s.delete();
            push_init();
            cyc            = 0;
            busy_end       = INIT_LEN;
            snap_at        = -1;
            model_busy     = 1'b1;
            cur_is_refresh = 1'b0;
            m_pending      = 1'b0;
            exp_done       = 1'b0;
        end else begin
            cyc++;
            exp_done = 1'b0;
            if (model_busy && cyc == busy_end) begin
                exp_done = cur_is_refresh;
                if (m_pending || update) begin
                    m_pending      = 1'b0;
                    cur_is_refresh = 1'b1;
                    busy_end       = cyc + REF_LEN;
                    snap_at        = cyc + 1;
                end else begin
                    model_busy = 1'b0;
                end
            end else if (update) begin
                if (!model_busy) begin
                    model_busy     = 1'b1;
                    cur_is_refresh = 1'b1;
                    busy_end       = cyc + REF_LEN;
                    push_refresh(digits);
                end else begin
                    m_pending = 1'b1;
                end
            end
            if (cyc == snap_at) push_refresh(digits);
        end
    end

    // ---------------- monitor ----------------
    logic       prev_e [2];
    logic [7:0] prev_db [2];
    logic       prev_rs [2];
    int         width [2];
    int         dones [2];

    initial begin
        dones[0] = 0;
        dones[1] = 0;
    end

    task automatic mon(input int w, input logic e, input logic [7:0] db, input logic rs,
                       input logic rw, input logic busy, input logic done);
        string      tag;
        logic [8:0] exp;
        bit         empty;
        tag = (w == 0) ? "hex" : "spc";
        check({tag, " rw"}, 32'(rw), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'(model_busy));
        check({tag, " done"}, 32'(done), 32'(exp_done));
        if (!busy) begin
            check({tag, " idle db"}, 32'(db), 32'hCC);
            check({tag, " idle rs"}, 32'(rs), 32'd0);
        end
        if (e && prev_e[w]) begin
            width[w]++;
            check({tag, " db stable during e"}, 32'(db), 32'(prev_db[w]));
            check({tag, " rs stable during e"}, 32'(rs), 32'(prev_rs[w]));
        end
        if (e && !prev_e[w]) begin
            width[w] = 1;
            empty = (w == 0) ? (exp_q_h.size() == 0) : (exp_q_s.size() == 0);
            checks++;
            if (empty) begin
                failures++;
                $display("FAIL %s unexpected byte: got rs=%0d db=0x%02h expected none", tag, rs, db);
            end else begin
                checks--;
                exp = (w == 0) ? exp_q_h.pop_front() : exp_q_s.pop_front();
                check({tag, " byte {rs,db}"}, 32'({rs, db}), 32'(exp));
            end
        end
        if (!e && prev_e[w]) check({tag, " e width"}, 32'(width[w]), 32'(EP));
        if (done) dones[w]++;
        prev_e[w]  = e;
        prev_db[w] = db;
        prev_rs[w] = rs;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                prev_e[i] = 1'b0;
                width[i]  = 0;
            end
        end else begin
            mon(0, e_h, db_h, rs_h, rw_h, busy_h, done_h);
            mon(1, e_s, db_s, rs_s, rw_s, busy_s, done_s);
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_update();
        @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string when);
        check({when, " hex db"}, 32'(db_h), 32'hCC);
        check({when, " hex e"}, 32'(e_h), 32'd0);
        check({when, " hex rs"}, 32'(rs_h), 32'd0);
        check({when, " hex busy"}, 32'(busy_h), 32'd1);
        check({when, " hex done"}, 32'(done_h), 32'd0);
        check({when, " spc db"}, 32'(db_s), 32'hCC);
        check({when, " spc e"}, 32'(e_s), 32'd0);
        check({when, " spc busy"}, 32'(busy_s), 32'd1);
    endtask

    int  d0;
    bit  got_e;

    initial begin
        // Reset state and init sequence.
        idle_cycles(3);
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(INIT_LEN - 1);
        check("busy before init end", 32'(busy_h), 32'd1);
        @(negedge clk);
        check("busy after init end", 32'(busy_h), 32'd0);
        check("idle db after init", 32'(db_h), 32'hCC);
        idle_cycles(3);

        // Basic refresh and done latency.
        digits = 16'h1234;
        pulse_update();
        check("busy after update", 32'(busy_h), 32'd1);
        idle_cycles(REF_LEN - 1);
        check("done not early", 32'(done_h), 32'd0);
        @(negedge clk);
        check("done at refresh end", 32'(done_h), 32'd1);
        idle_cycles(4);

        // Hex versus blank rendering.
        digits = 16'hA0F9;
        pulse_update();
        idle_cycles(REF_LEN + 5);

        // Pending merge: three requests during one refresh, digits change mid-way.
        digits = 16'h1111;
        d0 = dones[0];
        pulse_update();
        idle_cycles(4);
        pulse_update();
        idle_cycles(4);
        digits = 16'h5678;
        pulse_update();
        idle_cycles(4);
        pulse_update();
        idle_cycles(2 * REF_LEN);
        check("merge done pulses", 32'(dones[0] - d0), 32'd2);

        // Random update traffic.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            update = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) digits = 16'($urandom);
        end
        @(negedge clk);
        update = 1'b0;
        idle_cycles(3 * REF_LEN);

        // Reset in the middle of an enable pulse.
        digits = 16'h4321;
        pulse_update();
        got_e = 1'b0;
        for (int i = 0; i < 60 && !got_e; i++) begin
            @(negedge clk);
            got_e = e_h;
        end
        check("e seen before mid reset", 32'(got_e), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid-transfer reset");
        idle_cycles(3);
        rst_n = 1'b1;
        // Request during the power-up wait becomes a pending refresh.
        digits = 16'h9A3C;
        idle_cycles(4);
        pulse_update();
        idle_cycles(INIT_LEN + REF_LEN + 20);

        check("hex scoreboard drained", 32'(exp_q_h.size()), 32'd0);
        check("spc scoreboard drained", 32'(exp_q_s.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
